rect_draw_scheduler: RTL and testbench
======================================

Name: rect_draw_scheduler

Overview:
- Shares the single vga_adapter pixel-write port between up to NREQ rectangle requesters (snake head draw, tail erase, apple draw, score box).
- Each request names a rectangle: origin, size and colour.
- Grants one request at a time, round-robin, and sequences a pixel sweep that emits one plot per cycle.
- Replaces per-object draw/erase state chains in the top level; sits directly in front of vga_adapter.

Parameters:
- NREQ, 4, number of requesters.
- XSCREEN, 160, screen width in pixels.
- YSCREEN, 120, screen height in pixels.
- DW, 4, width/height field bits (max rectangle 15x15).

Ports:
- CLOCK_50  in  1  system clock.
- Resetn  in  1  synchronous, active-low reset.
- req  in  NREQ  level request, one bit per requester.
- rect_x  in  NREQ*8  origin X; requester i uses bits [8i+7:8i].
- rect_y  in  NREQ*7  origin Y; requester i uses bits [7i+6:7i].
- rect_w  in  NREQ*DW  rectangle width.
- rect_h  in  NREQ*DW  rectangle height.
- rect_colour  in  NREQ*3  rectangle colour.
- grant  out  NREQ  one-hot; high from the latch cycle through the last DRAW cycle.
- done  out  NREQ  one-cycle pulse to the granted requester on completion.
- busy  out  1  high in any state other than IDLE.
- vga_x  out  8  pixel X to vga_adapter.
- vga_y  out  7  pixel Y to vga_adapter.
- vga_colour  out  3  pixel colour to vga_adapter.
- plot  out  1  pixel write enable to vga_adapter.

Behaviour:
- Reset (synchronous, Resetn=0 at a CLOCK_50 edge):
  - state=IDLE.
  - grant, done, busy, plot = 0; vga_x, vga_y, vga_colour = 0.
  - Round-robin pointer = NREQ-1, so requester 0 has first priority.
- States:
  - IDLE:
    - If no req bit is high, stay in IDLE.
    - If any req bit is high, select the first set bit searching from pointer+1 with wrap-around.
    - Latch that requester's x, y, w, h and colour; clear xc and yc; assert grant.
    - If w==0 or h==0, go to DONE. Otherwise go to DRAW.
  - DRAW:
    - Every cycle: vga_x = x0+xc, vga_y = y0+yc, vga_colour = latched colour.
    - If xc != w-1: xc++.
    - Else: xc = 0 and yc++.
    - When xc==w-1 and yc==h-1, go to DONE.
  - DONE:
    - done[g] = 1 for exactly one cycle; grant = 0.
    - Pointer = g; go to IDLE.
- Outputs are registered. vga_x, vga_y, vga_colour and plot change together on the same edge.
- Latency:
  - req sampled high in IDLE at edge n: grant visible after edge n; first plot after edge n+1.
  - A w x h rectangle produces exactly w*h plot cycles; done follows in the next cycle.
  - Back-to-back requests cost 2 overhead cycles each (IDLE latch + DONE).
- Clipping:
  - Sums are computed at 9 bits (X) and 8 bits (Y).
  - If x0+xc >= XSCREEN or y0+yc >= YSCREEN: plot = 0 for that cycle, but the sweep still advances.
  - vga_x and vga_y take the truncated sum; their value is irrelevant when plot = 0.
- Parameters are latched at grant:
  - Requester inputs may change during DRAW with no effect.
  - Deasserting req mid-draw is ignored; the rectangle completes and done still pulses.
- A req still high after its done is re-arbitrated in the next IDLE. Other pending requesters are served first.
- Simultaneous requests: strictly round-robin. No requester waits more than NREQ-1 other grants.
- Reset mid-DRAW:
  - Aborts immediately; plot = 0 after the reset edge; no done pulse.
  - Partially drawn pixels remain in the frame buffer.

Decomposition:
- Shared package (vga_pkg):
  - XSCREEN, YSCREEN.
  - Colour constants: BLACK=3'b000, RED=3'b100, GREEN=3'b010.
  - State encodings for IDLE, DRAW, DONE.
- Sub-module rr_arbiter:
  - Combinational: inputs req and pointer; outputs one-hot select and its index.
  - Instantiated once; the pointer register lives in rect_draw_scheduler.

Test Plan:
- Single request, req[0] with x=39, y=59, w=10, h=10, colour=3'b010:
  - 100 plot cycles, pixels (39..48, 59..68) in row-major order, colour 010.
  - done[0] pulses once, in the cycle after the last plot.
  - grant[0] is high from the latch cycle through the last DRAW cycle.
- Contention, req[0] and req[2] raised on the same cycle, then req[0] re-raised after its done:
  - Grant order: 0, then 2, then 0.
  - plot is never high for two requesters' pixels in the same cycle.
- Clipping, x=155, y=115, w=10, h=10:
  - 25 plot=1 cycles covering (155..159, 115..119).
  - 100 DRAW cycles total; done pulses.
- Zero size, w=0, h=5:
  - No plot at all.
  - done pulses 2 cycles after the req is sampled.
- Reset mid-draw, Resetn=0 after 37 pixels of a 10x10:
  - plot=0, busy=0, grant=0 after the reset edge; no done.
  - After release, the same req restarts from pixel (x0, y0).
- Parameter stability: change rect_x[0] and drop req[0] during DRAW:
  - All 100 pixels use the latched origin; done[0] still pulses.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA drawing path.
//   XSCREEN / YSCREEN : visible frame-buffer size in pixels.
//   BLACK / RED / GREEN : 3-bit colour codes understood by vga_adapter.
//   S_IDLE / S_DRAW / S_DONE : rect_draw_scheduler state encodings.
package vga_pkg;

    localparam int XSCREEN = 160;
    localparam int YSCREEN = 120;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] GREEN = 3'b010;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DRAW = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector.
// Ports:
//   req  : request vector, one bit per requester.
//   ptr  : index of the most recently served requester; search starts at ptr+1.
//   sel  : one-hot selected requester (all zero when no request).
//   idx  : binary index of the selected requester.
//   any  : at least one request is pending.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] sel,
    output logic [IW-1:0]   idx,
    output logic            any
);

    int j;

    // Walk ptr+1, ptr+2, ... wrapping, and take the first set bit; ptr itself
    // is checked last so the previous winner has lowest priority.
    always_comb begin
        sel = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!any && req[j]) begin
                any    = 1'b1;
                sel[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/rect_draw_scheduler.sv
// Shares the single vga_adapter pixel-write port between NREQ rectangle
// requesters. One request is granted at a time (round-robin); the granted
// rectangle is swept row-major, one pixel per cycle, with off-screen pixels
// suppressed but still consuming a cycle.
// Ports:
//   CLOCK_50, Resetn      : clock, synchronous active-low reset.
//   req                   : level request per requester.
//   rect_x/y/w/h/colour   : packed per-requester rectangle descriptors.
//   grant                 : one-hot, high from latch through last DRAW cycle.
//   done                  : one-cycle completion pulse to the served requester.
//   busy                  : scheduler is not idle.
//   vga_x/vga_y/vga_colour/plot : registered pixel write to vga_adapter.
module rect_draw_scheduler
    import vga_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int XSCREEN = vga_pkg::XSCREEN,
    parameter int YSCREEN = vga_pkg::YSCREEN,
    parameter int DW      = 4
) (
    input  logic              CLOCK_50,
    input  logic              Resetn,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*8-1:0] rect_x,
    input  logic [NREQ*7-1:0] rect_y,
    input  logic [NREQ*DW-1:0] rect_w,
    input  logic [NREQ*DW-1:0] rect_h,
    input  logic [NREQ*3-1:0] rect_colour,
    output logic [NREQ-1:0]   grant,
    output logic [NREQ-1:0]   done,
    output logic              busy,
    output logic [7:0]        vga_x,
    output logic [6:0]        vga_y,
    output logic [2:0]        vga_colour,
    output logic              plot
);

    localparam int IW = $clog2(NREQ);

    logic [1:0]    state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] gidx;

    logic [7:0]    x0;
    logic [6:0]    y0;
    logic [DW-1:0] w_l, h_l;
    logic [2:0]    col;
    logic [DW-1:0] xc, yc;

    logic [NREQ-1:0] arb_sel;
    logic [IW-1:0]   arb_idx;
    logic            arb_any;

    logic [7:0]    sel_x;
    logic [6:0]    sel_y;
    logic [DW-1:0] sel_w, sel_h;
    logic [2:0]    sel_c;

    logic [8:0]    sum_x;
    logic [7:0]    sum_y;
    logic          in_bounds;
    logic          last_col, last_row;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req (req),
        .ptr (ptr),
        .sel (arb_sel),
        .idx (arb_idx),
        .any (arb_any)
    );

    always_comb begin
        sel_x = '0;
        sel_y = '0;
        sel_w = '0;
        sel_h = '0;
        sel_c = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_sel[i]) begin
                sel_x = rect_x[8*i +: 8];
                sel_y = rect_y[7*i +: 7];
                sel_w = rect_w[DW*i +: DW];
                sel_h = rect_h[DW*i +: DW];
                sel_c = rect_colour[3*i +: 3];
            end
        end
    end

    // One extra bit on each sum so origins near the right/bottom edge do not
    // wrap back on-screen before the bounds test.
    assign sum_x     = {1'b0, x0} + 9'(xc);
    assign sum_y     = {1'b0, y0} + 8'(yc);
    assign in_bounds = (sum_x < 9'(XSCREEN)) && (sum_y < 8'(YSCREEN));
    assign last_col  = (xc == w_l - DW'(1));
    assign last_row  = (yc == h_l - DW'(1));

    assign busy = (state != S_IDLE);

    // Rectangle descriptor, captured at grant so requesters may change or
    // drop their inputs during the sweep.
    always_ff @(posedge CLOCK_50) begin
        if (state == S_IDLE && arb_any) begin
            x0   <= sel_x;
            y0   <= sel_y;
            w_l  <= sel_w;
            h_l  <= sel_h;
            col  <= sel_c;
            gidx <= arb_idx;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            state      <= S_IDLE;
            ptr        <= IW'(NREQ - 1);
            grant      <= '0;
            done       <= '0;
            plot       <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            xc         <= '0;
            yc         <= '0;
        end else begin
            done <= '0;
            plot <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (arb_any) begin
                        grant <= arb_sel;
                        xc    <= '0;
                        yc    <= '0;
                        state <= (sel_w == '0 || sel_h == '0) ? S_DONE : S_DRAW;
                    end
                end
                S_DRAW: begin
                    vga_x      <= sum_x[7:0];
                    vga_y      <= sum_y[6:0];
                    vga_colour <= col;
                    plot       <= in_bounds;
                    if (last_col) begin
                        xc <= '0;
                        yc <= yc + DW'(1);
                        if (last_row) state <= S_DONE;
                    end else begin
                        xc <= xc + DW'(1);
                    end
                end
                S_DONE: begin
                    done  <= grant;
                    grant <= '0;
                    ptr   <= gidx;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rect_draw_scheduler.sv
// Scoreboard bench for rect_draw_scheduler: expected pixels and done pulses
// are queued as stimulus is issued, and a negedge monitor pops and compares
// them whenever the scheduler plots or signals completion.
module tb_rect_draw_scheduler;

    localparam int NREQ = 4;
    localparam int DW   = 4;

    logic              CLOCK_50 = 1'b0;
    logic              Resetn;
    logic [NREQ-1:0]   req;
    logic [NREQ*8-1:0] rect_x;
    logic [NREQ*7-1:0] rect_y;
    logic [NREQ*DW-1:0] rect_w;
    logic [NREQ*DW-1:0] rect_h;
    logic [NREQ*3-1:0] rect_colour;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   done;
    logic              busy;
    logic [7:0]        vga_x;
    logic [6:0]        vga_y;
    logic [2:0]        vga_colour;
    logic              plot;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    pix_t       exp_pix[$];
    logic [3:0] exp_done[$];
    pix_t       e_pix;
    pix_t       a_pix;
    logic [3:0] e_done;

    int checks = 0;
    int errors = 0;

    rect_draw_scheduler #(.NREQ(NREQ), .XSCREEN(160), .YSCREEN(120), .DW(DW)) dut (
        .CLOCK_50    (CLOCK_50),
        .Resetn      (Resetn),
        .req         (req),
        .rect_x      (rect_x),
        .rect_y      (rect_y),
        .rect_w      (rect_w),
        .rect_h      (rect_h),
        .rect_colour (rect_colour),
        .grant       (grant),
        .done        (done),
        .busy        (busy),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .plot        (plot)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: every plotted pixel and every done pulse must match the head
    // of the corresponding expectation queue.
    always @(negedge CLOCK_50) begin
        if (plot) begin
            checks++;
            a_pix = '{x: vga_x, y: vga_y, c: vga_colour};
            if (exp_pix.size() == 0) begin
                errors++;
                $display("FAIL pixel: unexpected plot at (%0d,%0d) colour %0d", vga_x, vga_y, vga_colour);
            end else begin
                e_pix = exp_pix.pop_front();
                if (a_pix !== e_pix) begin
                    errors++;
                    $display("FAIL pixel: got (%0d,%0d,c%0d) expected (%0d,%0d,c%0d)",
                             vga_x, vga_y, vga_colour, e_pix.x, e_pix.y, e_pix.c);
                end
            end
            checks++;
            if (!$onehot(grant)) begin
                errors++;
                $display("FAIL grant_onehot_at_plot: grant=%b expected exactly one bit", grant);
            end
        end
        if (done != '0) begin
            checks++;
            if (exp_done.size() == 0) begin
                errors++;
                $display("FAIL done: unexpected done=%b", done);
            end else begin
                e_done = exp_done.pop_front();
                if (done !== e_done) begin
                    errors++;
                    $display("FAIL done: got %b expected %b", done, e_done);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic load(input int i, input int x, input int y, input int w, input int h, input logic [2:0] c);
        rect_x[8*i +: 8]       = 8'(x);
        rect_y[7*i +: 7]       = 7'(y);
        rect_w[DW*i +: DW]     = DW'(w);
        rect_h[DW*i +: DW]     = DW'(h);
        rect_colour[3*i +: 3]  = c;
    endtask

    task automatic expect_rect(input int i, input int x, input int y, input int w, input int h, input logic [2:0] c);
        for (int yy = 0; yy < h; yy++)
            for (int xx = 0; xx < w; xx++)
                if (x + xx < 160 && y + yy < 120)
                    exp_pix.push_back('{x: 8'(x + xx), y: 7'(y + yy), c: c});
        exp_done.push_back(4'(1 << i));
    endtask

    // Wait at negedges for grant[i] (sel_done=0) or done[i] (sel_done=1).
    task automatic wait_bit(input int i, input bit sel_done, input string name);
        for (int k = 0; k < 400; k++) begin
            @(negedge CLOCK_50);
            if (sel_done ? done[i] : grant[i]) return;
        end
        checks++;
        errors++;
        $display("FAIL %s: timeout waiting, got 0 expected 1", name);
    endtask

    task automatic do_reset();
        Resetn = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        Resetn = 1'b1;
        @(negedge CLOCK_50);
    endtask

    // Raise req[i], confirm the latch cycle, then count sweep cycles and plots
    // until done[i]. Optionally disturb the requester inputs mid-sweep.
    task automatic run_rect(input int i, input int exp_cycles, input int exp_plots, input bit mutate, input string name);
        int  cyc;
        int  plots;
        bit  grant_lost;
        bit  got;
        cyc = 0; plots = 0; grant_lost = 0; got = 0;
        req[i] = 1'b1;
        wait_bit(i, 1'b0, {name, "_grant"});
        req[i] = 1'b0;
        check({name, "_latch_busy"}, 32'(busy), 32'd1);
        check({name, "_latch_plot"}, 32'(plot), 32'd0);
        for (int k = 0; k < 400; k++) begin
            @(negedge CLOCK_50);
            if (done[i]) begin
                got = 1;
                break;
            end
            cyc++;
            if (plot) plots++;
            if (!grant[i]) grant_lost = 1;
            if (mutate && cyc == 5) begin
                rect_x[8*i +: 8] = 8'd100;
                rect_y[7*i +: 7] = 7'd5;
                req[i] = 1'b0;
            end
        end
        check({name, "_done_seen"}, 32'(got), 32'd1);
        check({name, "_sweep_cycles"}, 32'(cyc), 32'(exp_cycles));
        check({name, "_plot_count"}, 32'(plots), 32'(exp_plots));
        check({name, "_grant_held"}, 32'(grant_lost), 32'd0);
        check({name, "_grant_dropped"}, 32'(grant), 32'd0);
    endtask

    initial begin
        int plots;
        Resetn      = 1'b0;
        req         = '0;
        rect_x      = '0;
        rect_y      = '0;
        rect_w      = '0;
        rect_h      = '0;
        rect_colour = '0;
        repeat (3) @(negedge CLOCK_50);

        check("reset_grant", 32'(grant), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_plot", 32'(plot), 32'd0);
        check("reset_vga", {14'd0, vga_x, vga_y, vga_colour}, 32'd0);
        Resetn = 1'b1;
        @(negedge CLOCK_50);

        // Single 10x10 green square at (39,59).
        load(0, 39, 59, 10, 10, 3'b010);
        expect_rect(0, 39, 59, 10, 10, 3'b010);
        run_rect(0, 100, 100, 1'b0, "single");
        @(negedge CLOCK_50);

        // Contention from a fresh pointer: order must be 0, 2, 0.
        do_reset();
        load(0, 10, 10, 3, 2, 3'b100);
        load(2, 20, 30, 2, 3, 3'b010);
        expect_rect(0, 10, 10, 3, 2, 3'b100);
        expect_rect(2, 20, 30, 2, 3, 3'b010);
        expect_rect(0, 10, 10, 3, 2, 3'b100);
        req[0] = 1'b1;
        req[2] = 1'b1;
        wait_bit(0, 1'b0, "cont_grant0_first");
        check("cont_first_is_0", 32'(grant), 32'b0001);
        req[0] = 1'b0;
        wait_bit(0, 1'b1, "cont_done0_first");
        req[0] = 1'b1;
        wait_bit(2, 1'b0, "cont_grant2");
        check("cont_second_is_2", 32'(grant), 32'b0100);
        req[2] = 1'b0;
        wait_bit(0, 1'b0, "cont_grant0_again");
        check("cont_third_is_0", 32'(grant), 32'b0001);
        req[0] = 1'b0;
        wait_bit(0, 1'b1, "cont_done0_again");
        @(negedge CLOCK_50);

        // Clipping at the bottom-right corner.
        load(1, 155, 115, 10, 10, 3'b100);
        expect_rect(1, 155, 115, 10, 10, 3'b100);
        run_rect(1, 100, 25, 1'b0, "clip");
        @(negedge CLOCK_50);

        // Zero width: no pixels, done right after the latch cycle.
        load(3, 5, 5, 0, 5, 3'b010);
        expect_rect(3, 5, 5, 0, 5, 3'b010);
        run_rect(3, 0, 0, 1'b0, "zero");
        @(negedge CLOCK_50);

        // Reset after 37 pixels, then the held request restarts from origin.
        load(0, 0, 0, 10, 10, 3'b100);
        expect_rect(0, 0, 0, 10, 10, 3'b100);
        req[0] = 1'b1;
        wait_bit(0, 1'b0, "rst_grant");
        plots = 0;
        for (int k = 0; k < 200 && plots < 37; k++) begin
            @(negedge CLOCK_50);
            if (plot) plots++;
        end
        check("rst_pixels_before", 32'(plots), 32'd37);
        Resetn = 1'b0;
        @(negedge CLOCK_50);
        check("rst_plot", 32'(plot), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant_off", 32'(grant), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        exp_pix.delete();
        exp_done.delete();
        expect_rect(0, 0, 0, 10, 10, 3'b100);
        Resetn = 1'b1;
        run_rect(0, 100, 100, 1'b0, "restart");
        @(negedge CLOCK_50);

        // Inputs disturbed mid-sweep must not affect the latched rectangle.
        load(2, 60, 40, 10, 10, 3'b010);
        expect_rect(2, 60, 40, 10, 10, 3'b010);
        run_rect(2, 100, 100, 1'b1, "stable");

        repeat (3) @(negedge CLOCK_50);
        check("final_pixels_left", 32'(exp_pix.size()), 32'd0);
        check("final_done_left", 32'(exp_done.size()), 32'd0);
        check("final_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
